// File: rtl/crosswalk_request_pkg.sv
// Shared definitions for the crosswalk request front end: FSM state encodings
// and the default timing constants also used by the pedestrian signal block.
package crosswalk_request_pkg;

  // Encodings are visible on the wire to pedestrianSignal debug, keep them fixed.
  typedef enum logic [1:0] {
    PedIdle    = 2'd0,
    PedRequest = 2'd1,
    PedLockout = 2'd2
  } ped_state_e;

  localparam int unsigned DefDebounceCycles = 16;
  localparam int unsigned DefLockoutCycles  = 64;
  localparam int unsigned DefCntW           = 8;

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchroniser plus counter debouncer for the raw crosswalk button.
// The clean level only follows the synchronised level after it has been
// different for DEBOUNCE_CYCLES consecutive cycles. The rise output flags the
// cycle just before the clean level goes high; releases produce no event.
module button_debouncer
  import crosswalk_request_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles,
  parameter int unsigned CNT_W           = DefCntW
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic clean,
  output logic rise
);

  localparam logic [CNT_W-1:0] DbLast = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_q;
  logic             s2_q;
  logic             clean_q;
  logic             clean_d;
  logic [CNT_W-1:0] db_cnt_q;
  logic [CNT_W-1:0] db_cnt_d;
  logic             at_last;

  // Debounce next state: count while the synchronised level disagrees,
  // restart on any agreement so a single bounce resets the window.
  always_comb begin
    at_last  = (db_cnt_q == DbLast);
    clean_d  = clean_q;
    db_cnt_d = '0;
    if (s2_q != clean_q) begin
      if (at_last) begin
        clean_d = s2_q;
      end else begin
        db_cnt_d = db_cnt_q + CNT_W'(1);
      end
    end
  end

  // Synchroniser and debounce state.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      clean_q  <= 1'b0;
      db_cnt_q <= '0;
    end else begin
      s1_q     <= raw;
      s2_q     <= s1_q;
      clean_q  <= clean_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  assign clean = clean_q;
  assign rise  = s2_q & ~clean_q & at_last;

endmodule

// File: rtl/crosswalk_request.sv
// Crosswalk request front end. Turns each debounced button press into a level
// walk_req held until walk_ack, then runs a lockout window during which one
// press can be remembered and issued the moment lockout ends.
module crosswalk_request
  import crosswalk_request_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles,
  parameter int unsigned LOCKOUT_CYCLES  = DefLockoutCycles,
  parameter int unsigned CNT_W           = DefCntW
) (
  input  logic clk,
  input  logic reset,
  input  logic button_in,
  input  logic walk_ack,
  output logic walk_req,
  output logic lockout,
  output logic queued,
  output logic button_clean
);

  localparam logic [CNT_W-1:0] LkLast = CNT_W'(LOCKOUT_CYCLES - 1);

  logic             press;
  ped_state_e       state_q;
  ped_state_e       state_d;
  logic [CNT_W-1:0] lk_cnt_q;
  logic [CNT_W-1:0] lk_cnt_d;
  logic             queued_q;
  logic             queued_d;
  logic             walk_req_q;
  logic             lockout_q;

  button_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_debouncer (
    .clk   (clk),
    .reset (reset),
    .raw   (button_in),
    .clean (button_clean),
    .rise  (press)
  );

  // Next-state logic for the request / lockout sequencer.
  always_comb begin
    state_d  = state_q;
    lk_cnt_d = lk_cnt_q;
    queued_d = queued_q;
    unique case (state_q)
      PedIdle: begin
        // walk_ack has nothing to acknowledge here.
        if (press) begin
          state_d = PedRequest;
        end
      end
      PedRequest: begin
        // A press while already requesting merges into the pending request.
        if (walk_ack) begin
          state_d  = PedLockout;
          lk_cnt_d = LkLast;
        end
      end
      PedLockout: begin
        if (lk_cnt_q == '0) begin
          // A press landing on the final cycle is as good as a queued one.
          state_d  = (queued_q | press) ? PedRequest : PedIdle;
          queued_d = 1'b0;
        end else begin
          lk_cnt_d = lk_cnt_q - CNT_W'(1);
          if (press) begin
            queued_d = 1'b1;
          end
        end
      end
      default: begin
        state_d  = PedIdle;
        queued_d = 1'b0;
      end
    endcase
  end

  // Sequencer state with outputs registered from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= PedIdle;
      lk_cnt_q   <= '0;
      queued_q   <= 1'b0;
      walk_req_q <= 1'b0;
      lockout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      lk_cnt_q   <= lk_cnt_d;
      queued_q   <= queued_d;
      walk_req_q <= (state_d == PedRequest);
      lockout_q  <= (state_d == PedLockout);
    end
  end

  assign walk_req = walk_req_q;
  assign lockout  = lockout_q;
  assign queued   = queued_q;

endmodule
